// File: rtl/fft_pkg.sv
// Shared constants and issue-FSM state type for the fft frame loader and its banks.
package fft_pkg;
    localparam int FFT_N      = 8;
    localparam int FFT_DATA_W = 16;
    localparam int FFT_IDX_W  = 3;
    localparam int FFT_FLAT_W = FFT_N * FFT_DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } issue_state_t;
endpackage

// File: rtl/fft_frame_bank.sv
// One 8-entry complex frame buffer: sequential fill, zero-fill on early close, full flag.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N      = FFT_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                last,
    input  logic                clear,
    input  logic [DATA_W-1:0]   wr_real,
    input  logic [DATA_W-1:0]   wr_imag,
    output logic [N*DATA_W-1:0] data_real,
    output logic [N*DATA_W-1:0] data_imag,
    output logic                full,
    output logic                close,
    output logic                short_close
);
    logic [N-1:0][DATA_W-1:0] re_q, im_q;
    logic [FFT_IDX_W-1:0]     idx;
    logic                     at_end;

    assign at_end      = (idx == FFT_IDX_W'(N - 1));
    assign close       = wr_en && (at_end || last);
    assign short_close = wr_en && last && !at_end;
    assign data_real   = re_q;
    assign data_imag   = im_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            re_q <= '0;
            im_q <= '0;
            idx  <= '0;
            full <= 1'b0;
        end else begin
            // clear and wr_en never coincide: a bank is only written while not full
            if (clear)
                full <= 1'b0;
            if (wr_en) begin
                for (int k = 0; k < N; k++) begin
                    if (FFT_IDX_W'(k) == idx) begin
                        re_q[k] <= wr_real;
                        im_q[k] <= wr_imag;
                    end else if (last && (FFT_IDX_W'(k) > idx)) begin
                        re_q[k] <= '0;
                        im_q[k] <= '0;
                    end
                end
                if (close) begin
                    full <= 1'b1;
                    idx  <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-frame loader for the 8-point fft core: ping-pong banks plus write/start/wait issue FSM.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N      = FFT_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_real,
    input  logic [DATA_W-1:0]   in_imag,
    input  logic                in_last,
    output logic                fft_write,
    output logic                fft_start,
    input  logic                fft_ready,
    output logic [N*DATA_W-1:0] frame_real,
    output logic [N*DATA_W-1:0] frame_imag,
    output logic                short_err
);
    issue_state_t state, state_nxt;
    logic fill_sel, issue_sel, fft_ready_q, short_q;
    logic accept, done;
    logic [1:0] full, close, short_close, wr_en, clear;
    logic [1:0][N*DATA_W-1:0] bank_real, bank_imag;

    assign in_ready = !full[fill_sel];
    assign accept   = in_valid && in_ready;
    assign done     = (state == BUSY) && fft_ready && !fft_ready_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign wr_en[b] = accept && (fill_sel == (b != 0));
        assign clear[b] = done && (issue_sel == (b != 0));

        fft_frame_bank #(.DATA_W(DATA_W), .N(N)) u_bank (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (wr_en[b]),
            .last        (in_last),
            .clear       (clear[b]),
            .wr_real     (in_real),
            .wr_imag     (in_imag),
            .data_real   (bank_real[b]),
            .data_imag   (bank_imag[b]),
            .full        (full[b]),
            .close       (close[b]),
            .short_close (short_close[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_sel    <= 1'b0;
            issue_sel   <= 1'b0;
            fft_ready_q <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            fft_ready_q <= fft_ready;
            short_q     <= |short_short_or();
            if (|close)
                fill_sel <= !fill_sel;
            if (done)
                issue_sel <= !issue_sel;
        end
    end

    function automatic logic [1:0] short_short_or();
        return short_close;
    endfunction

    // A close into the issue bank jumps straight to WRITE so fft_write lands one cycle after it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[issue_sel] || close[issue_sel]) state_nxt = WRITE;
            WRITE:   state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fft_write  = (state == WRITE) && !rst;
        fft_start  = (state == START) && !rst;
        short_err  = short_q && !rst;
        frame_real = bank_real[issue_sel];
        frame_imag = bank_imag[issue_sel];
    end
endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Upstream feeder for the 8-point `fft` core. It accepts a serial stream of complex 16-bit samples, one per cycle, over a valid/ready handshake and assembles each group of 8 samples into a parallel frame. It then drives the core's `write`/`start` sequence and holds the frame stable until the core signals completion. Two frame banks are used in ping-pong, so one frame can fill while the other is being transformed.

## Interface
- `DATA_W`, 16: sample width per real/imag component, two's complement.
- `N`, 8: frame length; fixed at 8 to match `fft`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: loader can accept a sample this cycle.
- `in_real` in DATA_W: input sample, real part.
- `in_imag` in DATA_W: input sample, imaginary part.
- `in_last` in 1: marks the final sample of a frame. Optional on index 7; it forces early close on indices 0–6.
- `fft_write` out 1: one-cycle pulse; the frame outputs are valid for the core to latch.
- `fft_start` out 1: one-cycle pulse on the cycle after `fft_write`.
- `fft_ready` in 1: completion from `fft`, sampled for a rising edge.
- `frame_real` out N*DATA_W: sample k occupies bits [k*DATA_W +: DATA_W]. Maps to `input0_real`..`input7_real`.
- `frame_imag` out N*DATA_W: same packing, imaginary parts.
- `short_err` out 1: one-cycle pulse when a frame is closed early by `in_last`.

## Operation
- **Banks.** There are banks A and B, each holding 8 complex entries, a 3-bit write index and a `full` flag.
  - `fill_sel` selects the bank being filled; `issue_sel` selects the bank driven on `frame_*`.
- **Accept.**
  - `in_ready = !full[fill_sel]`.
  - A sample is accepted when `in_valid && in_ready`. It is written to entry `idx`, and `idx` then increments.
  - On the accept at `idx`==7, or an accept with `in_last`: set `full`, reset `idx` to 0, toggle `fill_sel`.
- **Short frame.** An accept with `in_last` at `idx`<7 zero-fills entries `idx+1`..7 in the same cycle, closes the frame and pulses `short_err` on the next cycle.
  - `in_last` at `idx`==7 is a normal close with no error.
- **Issue FSM** (states IDLE, WRITE, START, BUSY):
  - IDLE → WRITE when `full[issue_sel]`.
  - WRITE: `fft_write`=1 → START.
  - START: `fft_start`=1 → BUSY.
  - BUSY: wait for `fft_ready && !fft_ready_q`, where `fft_ready_q` is `fft_ready` registered one cycle. On that edge: clear `full[issue_sel]`, toggle `issue_sel`, go to IDLE.
- **Frame stability.** `frame_*` follows `issue_sel` and is constant from WRITE through the completion cycle.
- **No arithmetic.** Data passes through bit-exact; there is no scaling or saturation.

## Timing
- **Reset values:** `in_ready`=1, `fft_write`=0, `fft_start`=0, `short_err`=0, `frame_*`=0.
  - All bank contents, indices, `full` flags, `fill_sel`/`issue_sel` (both bank A), FSM (IDLE) and `fft_ready_q` are cleared.
- **Latency.** The closing accept happens at cycle t (IDLE, bank free). Then `fft_write` is high at t+1 and `fft_start` at t+2.
- **Both banks full.** `in_ready` is 0 until the completion edge. It returns to 1 on the cycle after that edge.
- **Simultaneous events.** A closing accept into one bank in the same cycle as completion of the other bank is legal. Both updates take effect, and the FSM goes IDLE → WRITE on the following cycle.
- **Stale ready.** A `fft_ready` level that is already high when entering BUSY does not complete the frame; a fresh rising edge is required.
- **Reset mid-operation.** `rst` during fill or BUSY discards all frames. No pulse is emitted in the reset cycle or the cycle after it.
- **Input holding.** `in_valid` may drop at any time; the partial frame is held indefinitely.

## Structure
- `fft_pkg` holds:
  - `FFT_N`=8, `FFT_DATA_W`=16, `FFT_IDX_W`=3;
  - the issue-FSM state enum (IDLE/WRITE/START/BUSY);
  - the flat-bus slice helper constants.
- Sub-module `fft_frame_bank` is one 8-entry complex register bank with write index, zero-fill on short close, and `full` flag. It is instantiated twice.
- The top level contains bank select, the issue FSM, `fft_ready` edge detection and output muxing.
- Top level plus bank is roughly 200–300 lines.

## Test plan
- **Ramp frame:** stream real 0,256,512,…,1792, imag 0, `in_valid` continuous.
  - `fft_write` 1 cycle after the 8th accept, `fft_start` the next cycle.
  - `frame_real` slice k = 256·k; `frame_imag` = 0.
- **Back-to-back frames:** stream 24 samples continuously with `fft_ready` withheld.
  - Banks A and B fill; `in_ready` drops after sample 16.
  - A `fft_ready` edge releases A; sample 17 is accepted the next cycle; the B frame issues.
- **Short frame:** `in_last` on the 3rd sample (values 5,6,7).
  - Slices 0..2 = 5,6,7 and slices 3..7 = 0; `short_err` is a single pulse; the frame issues normally.
- **Stale ready:** `fft_ready` held at 1 before and through WRITE/START.
  - The loader stays in BUSY until `fft_ready` goes 0 and then returns to 1.
- **Reset mid-fill and mid-BUSY:** apply `rst` after 4 accepts, and again while in BUSY.
  - All outputs return to reset values; the next 8 samples form a clean frame in bank A.
- **Backpressure:** random `in_valid` gaps.
  - Frame contents match the stream order exactly; no sample is lost or duplicated.
